// File: rtl/sram_mem_controller_if.sv
// -----------------------------------------------------------------------------
// sram_mem_controller_if
// Pipeline-side memory-stage bus between the EXE/MEM register and the SRAM
// controller.
//   MEM_R_En / MEM_W_En : load / store request (held while ready is low)
//   address             : byte address (ALU result)
//   writeData           : store data
//   readData            : load result, valid when ready returns high
//   ready               : 1 = no access in progress or access completes now
// master = pipeline side, slave = controller side.
// -----------------------------------------------------------------------------
interface sram_mem_controller_if;
   logic        MEM_R_En;
   logic        MEM_W_En;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;

   modport master (
      output MEM_R_En, MEM_W_En, address, writeData,
      input  readData, ready
   );

   modport slave (
      input  MEM_R_En, MEM_W_En, address, writeData,
      output readData, ready
   );
endinterface

// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
// Memory-stage consumer of the EXE/MEM register. Performs one 32-bit load or
// store on an external 16-bit asynchronous SRAM as two half-word accesses
// (low half first), each held on the bus for ACCESS_CYCLES clocks. ready is
// low for the whole access so the top level can stall the pipeline.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   bus        : pipeline-side request/response (slave modport)
//   SRAM_DQ    : bidirectional SRAM data bus
//   SRAM_ADDR  : SRAM half-word address {word address, half select}
//   SRAM_WE_N, SRAM_OE_N : write / output enable, active low
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N : tied active (0)
// -----------------------------------------------------------------------------
module sram_mem_controller #(
   parameter int BASE_ADDR     = 1024,
   parameter int ACCESS_CYCLES = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   sram_mem_controller_if.slave        bus,
   inout  wire  [15:0]                 SRAM_DQ,
   output logic [17:0]                 SRAM_ADDR,
   output logic                        SRAM_WE_N,
   output logic                        SRAM_OE_N,
   output logic                        SRAM_CE_N,
   output logic                        SRAM_UB_N,
   output logic                        SRAM_LB_N
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
   // A one-cycle half has only its "last" cycle, so WE_N never goes low.
   localparam logic FIRST_WE_N = (ACCESS_CYCLES == 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_wr;
   logic [16:0] r_wa;
   logic [15:0] r_wdata_hi;
   logic [31:0] r_rdata;
   logic [17:0] r_addr;
   logic        r_we_n;
   logic        r_oe_n;
   logic        r_dq_oe;
   logic [15:0] r_dq_out;

   logic        w_req;
   logic        w_last;
   logic        w_ready;
   logic [16:0] w_wa;

   assign w_req  = bus.MEM_R_En | bus.MEM_W_En;
   assign w_last = (r_cnt == LAST);
   // Byte offset from the SRAM base, in 32-bit words; address[1:0] drops out.
   assign w_wa   = 17'((bus.address - 32'(BASE_ADDR)) >> 2);

   // Outputs are registered: each transition loads the bus values that the
   // next state must present, so SRAM pins always match the current state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_wr       <= 1'b0;
         r_wa       <= 17'd0;
         r_wdata_hi <= 16'd0;
         r_rdata    <= 32'd0;
         r_addr     <= 18'd0;
         r_we_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_dq_oe    <= 1'b0;
         r_dq_out   <= 16'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  // Store wins when both enables are set.
                  r_state    <= LOW;
                  r_cnt      <= 4'd0;
                  r_wr       <= bus.MEM_W_En;
                  r_wa       <= w_wa;
                  r_wdata_hi <= bus.writeData[31:16];
                  r_addr     <= {w_wa, 1'b0};
                  r_we_n     <= ~bus.MEM_W_En | FIRST_WE_N;
                  r_oe_n     <= bus.MEM_W_En;
                  r_dq_oe    <= bus.MEM_W_En;
                  r_dq_out   <= bus.writeData[15:0];
               end
            end
            LOW: begin
               if (w_last) begin
                  r_state  <= HIGH;
                  r_cnt    <= 4'd0;
                  r_addr   <= {r_wa, 1'b1};
                  r_dq_out <= r_wdata_hi;
                  r_we_n   <= ~r_wr | FIRST_WE_N;
                  if (!r_wr) r_rdata[15:0] <= SRAM_DQ;
               end else begin
                  r_cnt  <= r_cnt + 4'd1;
                  // WE_N rises for the final cycle so data outlives the WE edge.
                  r_we_n <= ~r_wr | (r_cnt + 4'd1 == LAST);
               end
            end
            HIGH: begin
               if (w_last) begin
                  r_state <= DONE;
                  r_we_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_dq_oe <= 1'b0;
                  if (!r_wr) r_rdata[31:16] <= SRAM_DQ;
               end else begin
                  r_cnt  <= r_cnt + 4'd1;
                  r_we_n <= ~r_wr | (r_cnt + 4'd1 == LAST);
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Combinational so the stall appears in the same cycle as the request.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         IDLE:    w_ready = ~w_req;
         DONE:    w_ready = 1'b1;
         default: w_ready = 1'b0;
      endcase
   end

   assign bus.ready    = w_ready;
   assign bus.readData = r_rdata;

   assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'bz;
   assign SRAM_ADDR = r_addr;
   assign SRAM_WE_N = r_we_n;
   assign SRAM_OE_N = r_oe_n;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Memory-stage consumer of the EXE/MEM pipeline register.
- Takes the registered MEM_R_En/MEM_W_En, ALU_result (byte address) and readdata (store data), and performs one 32-bit load or store on the external 16-bit asynchronous SRAM as two half-word accesses.
- Drives ready low for the whole access; the top level feeds ~ready back as superStall to freeze the pipeline registers.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ACCESS_CYCLES, 3: clock cycles each half-word access is held on the SRAM bus (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- MEM_R_En  input  1  load request from the EXE/MEM register.
- MEM_W_En  input  1  store request from the EXE/MEM register.
- address  input  32  byte address (ALU_result).
- writeData  input  32  store data (readdata field).
- readData  output  32  load result.
- ready  output  1  1 = no access in progress or access completes this cycle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  write enable, active low.
- SRAM_OE_N  output  1  output enable, active low.
- SRAM_CE_N  output  1  chip enable, active low; tied 0.
- SRAM_UB_N  output  1  upper byte enable, active low; tied 0.
- SRAM_LB_N  output  1  lower byte enable, active low; tied 0.

Behaviour:
- Reset values: state IDLE, cycle counter 0, readData 0, SRAM_WE_N 1, SRAM_OE_N 1, SRAM_ADDR 0, SRAM_DQ high-Z. ready follows its combinational rule.
- Word address: wa = (address - BASE_ADDR) >> 2, truncated to 17 bits. address[1:0] is ignored.
- SRAM_ADDR = {wa, h}, where h = 0 selects the low half (bits 15:0) and h = 1 the high half (bits 31:16).
- req = MEM_R_En | MEM_W_En. If both are set, the access is a store (write priority).
- ready = ~req in IDLE; 0 in LOW and HIGH; 1 in DONE. This is combinational, so the stall is asserted in the same cycle the request appears.
- FSM:
  - IDLE: if req, latch the access type (wr), wa and writeData, clear the counter, go to LOW. Otherwise stay.
  - LOW: drive h = 0 for ACCESS_CYCLES cycles (counter 0..ACCESS_CYCLES-1), then go to HIGH with the counter cleared.
  - HIGH: drive h = 1 for ACCESS_CYCLES cycles, then go to DONE.
  - DONE: one cycle with ready = 1 so the pipeline advances; then go to IDLE.
- Total stall per access is 2*ACCESS_CYCLES+1 cycles. The request is visible again in IDLE only after the pipeline has moved, so the same instruction is never re-executed.
- Write:
  - SRAM_WE_N = 0 during LOW and HIGH, except the last cycle of each half, where it is 1 so data is held past the WE rising edge.
  - SRAM_DQ is driven with wdata[15:0] in LOW and wdata[31:16] in HIGH.
  - SRAM_OE_N = 1 throughout.
- Read:
  - SRAM_OE_N = 0 in LOW and HIGH; SRAM_DQ is high-Z.
  - On the last cycle of LOW, SRAM_DQ is registered into readData[15:0]; on the last cycle of HIGH, into readData[31:16].
  - readData is valid in DONE and holds until the next load overwrites it. Stores never change readData.
- Inputs are latched in IDLE, so changes on address/writeData/enables during LOW or HIGH are ignored.
- Outside LOW/HIGH: SRAM_DQ is high-Z, SRAM_WE_N = 1, SRAM_OE_N = 1.
- Reset asserted mid-access: the module returns to IDLE immediately (asynchronous), WE_N goes to 1, the bus is released, and readData is cleared to 0. After reset the pipeline re-issues from its own reset state.
- Back-to-back accesses: a second request presented in the IDLE cycle right after DONE starts a new access with no extra gap.

Test Plan (ACCESS_CYCLES=3, behavioural SRAM model with 1-cycle read latency):
- No request for 10 cycles -> ready = 1 every cycle, SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ = Z.
- Store address=1028, writeData=0xDEADBEEF -> ready = 0 for exactly 7 cycles then 1 for one cycle; model SRAM[2] = 0xBEEF, SRAM[3] = 0xDEAD; WE_N low 2 cycles per half.
- Load address=1028 after the previous store -> readData = 0xDEADBEEF in the DONE cycle; ready low for 7 cycles.
- MEM_R_En=1 and MEM_W_En=1 together, address=1024, writeData=0x12345678 -> treated as a store: SRAM[0] = 0x5678, SRAM[1] = 0x1234, readData unchanged.
- Change address/writeData during the LOW state of a store -> SRAM contents reflect the values latched at IDLE only.
- Assert rst during the HIGH state of a store -> in the same cycle: WE_N = 1, DQ = Z, readData = 0. After release, ready = 1 with no request, and SRAM[1] is not written with new high data.
